moving_avg_multi: RTL and testbench
===================================

Name: moving_avg_multi

Overview:
- Parametrised successor to the team's 3-channel, 2-bit, window-4 moving-average block.
- Adds configurable channel count, sample width and power-of-two window, with full-precision running sums (no wrap).
- Adds a sum/average mode, a valid handshake, synchronous clear and a fill indicator.
- Sits between the packed `ui_in` sample bus and `uo_out` in the top-level wrapper; the wrapper does the pin packing.

Parameters:
- CHANNELS, 3, number of independent channels.
- DATA_W, 2, unsigned sample width per channel.
- LOG2_WIN, 2, log2 of window depth; WIN = 2^LOG2_WIN, legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable; low freezes all state.
- in_valid  in  1  sample strobe; a sample is accepted when ena && in_valid.
- in_data  in  CHANNELS*DATA_W  packed samples; channel c = in_data[c*DATA_W +: DATA_W].
- clear  in  1  synchronous flush of history, sums and count.
- mode  in  1  0 = average output, 1 = raw window sum.
- out_en  in  1  output gate; low forces out_data to 0.
- out_valid  out  1  one-cycle pulse when out_data updates.
- out_data  out  CHANNELS*OUT_W  per-channel result, OUT_W = DATA_W+LOG2_WIN; channel c at [c*OUT_W +: OUT_W].
- filled  out  1  high once WIN samples have been accepted since reset/clear.

Behaviour:
- Reset (rst_n low, async):
  - History, sums and count go to 0.
  - Output register, out_valid and filled go to 0.
  - Release is synchronous to clk.
- Storage per channel:
  - WIN-deep shift history of DATA_W bits plus an OUT_W-bit running sum.
  - The running sum is exact: max value WIN*(2^DATA_W-1) fits OUT_W, so it never wraps.
- Accept cycle (ena && in_valid && !clear), per channel:
  - sum_next = sum + new - oldest.
  - Shift history; the new sample enters the newest slot and the oldest is discarded.
  - count saturates at WIN.
- Partial fill:
  - Empty history slots hold 0, so the sum equals the sum of the samples accepted so far.
  - Average is still sum_next >> LOG2_WIN (divide by WIN, not by count).
- Output register:
  - Loaded on the accept cycle from sum_next.
  - mode=1: field = sum_next.
  - mode=0: field = sum_next >> LOG2_WIN, zero-extended; upper LOG2_WIN bits are 0; truncating (floor) division.
  - mode is sampled on the accept cycle only. Changing mode between accepts does not alter the held value.
- Latency: out_data and out_valid reflect a sample one cycle after its accept edge. out_valid is high for exactly that one cycle.
- No accept: out_data holds its value and out_valid = 0.
- filled: registered; asserts in the same cycle out_valid reports the WIN-th accepted sample; stays high until reset or clear.
- clear (synchronous, requires ena):
  - Zeros history, sums, count, output register and filled.
  - out_valid = 0 next cycle.
  - clear beats in_valid in the same cycle; that sample is dropped.
- ena low: nothing updates, including clear. Outputs hold; out_valid = 0.
- out_en:
  - Purely combinational AND on out_data; out_valid and filled are not gated.
  - Internal state advances regardless of out_en.
- Channels are fully independent; no cross-channel arithmetic.
- Reset mid-window: all state is lost. The first sample after release behaves as the first ever.

Test Plan:
- Fill and steady state (defaults). Ch0 samples 3,3,3,3 with mode=1 → out_data ch0 3,6,9,12; filled rises with the 4th result. Then sample 0 → 9.
- Average mode, same stream with mode=0 → ch0 0,1,2,3, then 2 after the trailing 0.
- Channel independence. Each accept drives ch0=1, ch1=2, ch2=3 (in_data = 6'b111001). After 4 accepts, mode=1 → fields 4,8,12; mode=0 → fields 1,2,3.
- Gaps, gating and ena:
  - in_valid low for 5 cycles → out_data holds and out_valid stays 0.
  - out_en low → out_data = 0 while the sum keeps advancing. Raising out_en shows the correct running value.
  - ena low → nothing changes.
- Clear collision. After filled, assert clear with in_valid=1 and data 3:
  - Next cycle: out_data = 0, filled = 0, out_valid = 0.
  - The next accept of 3 gives sum 3.
- Async reset mid-stream. Drop rst_n between clock edges → outputs go to 0 immediately. After release, samples 2,2 → sums 2,4 with filled = 0.

Source files
------------

// File: rtl/moving_avg_multi.sv
// moving_avg_multi: per-channel moving average (or raw window sum) over a
// power-of-two window. The running sums are exact and never wrap.
//
// Handshake: a sample is accepted on a rising clk edge when ena && in_valid
// && !clear. out_valid pulses for exactly one cycle, one cycle after the
// accept edge, and at the same time out_data shows that accept's result.
// There is no back-pressure, so the block never stalls the producer.
module moving_avg_multi #(
   parameter int CHANNELS = 3,
   parameter int DATA_W   = 2,
   parameter int LOG2_WIN = 2
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   ena,
   input  logic                                   in_valid,
   input  logic [CHANNELS*DATA_W-1:0]             in_data,
   input  logic                                   clear,
   input  logic                                   mode,
   input  logic                                   out_en,
   output logic                                   out_valid,
   output logic [CHANNELS*(DATA_W+LOG2_WIN)-1:0]  out_data,
   output logic                                   filled
);

   localparam int WIN   = 1 << LOG2_WIN;
   localparam int OUT_W = DATA_W + LOG2_WIN;
   localparam int CNT_W = LOG2_WIN + 1;
   localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN);

   // r_hist[c][0] is the oldest sample, r_hist[c][WIN-1] the newest.
   logic [DATA_W-1:0]         r_hist [CHANNELS][WIN];
   logic [OUT_W-1:0]          r_sum  [CHANNELS];
   logic [OUT_W-1:0]          w_sum_next [CHANNELS];
   logic [CHANNELS*OUT_W-1:0] r_out;
   logic [CHANNELS*OUT_W-1:0] w_out_next;
   logic [CNT_W-1:0]          r_count;
   logic [CNT_W-1:0]          w_count_next;
   logic                      r_valid;
   logic                      r_filled;
   logic                      w_accept;
   logic                      w_clear;

   // clear needs ena and always wins over a same-cycle sample.
   assign w_accept = ena && in_valid && !clear;
   assign w_clear  = ena && clear;

   // Saturating count of accepted samples since reset/clear.
   assign w_count_next = (r_count == WIN_CNT) ? WIN_CNT : r_count + CNT_W'(1);

   // Next running sum and the output field selected by mode; the sum cannot
   // overflow because the oldest sample is already part of it.
   always_comb begin
      w_out_next = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_sum_next[c] = r_sum[c]
                       + OUT_W'(in_data[c*DATA_W +: DATA_W])
                       - OUT_W'(r_hist[c][0]);
         w_out_next[c*OUT_W +: OUT_W] = mode ? w_sum_next[c]
                                             : (w_sum_next[c] >> LOG2_WIN);
      end
   end

   // History shift registers and running sums, one set per channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sum[c] <= '0;
            for (int i = 0; i < WIN; i++) r_hist[c][i] <= '0;
         end
      end else if (w_clear) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sum[c] <= '0;
            for (int i = 0; i < WIN; i++) r_hist[c][i] <= '0;
         end
      end else if (w_accept) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sum[c] <= w_sum_next[c];
            for (int i = 0; i < WIN - 1; i++) r_hist[c][i] <= r_hist[c][i+1];
            r_hist[c][WIN-1] <= in_data[c*DATA_W +: DATA_W];
         end
      end
   end

   // Fill counter, output register, valid pulse and fill flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_out    <= '0;
         r_valid  <= 1'b0;
         r_filled <= 1'b0;
      end else if (!ena) begin
         r_valid <= 1'b0;
      end else if (w_clear) begin
         r_count  <= '0;
         r_out    <= '0;
         r_valid  <= 1'b0;
         r_filled <= 1'b0;
      end else if (w_accept) begin
         r_count  <= w_count_next;
         r_out    <= w_out_next;
         r_valid  <= 1'b1;
         r_filled <= (w_count_next == WIN_CNT);
      end else begin
         r_valid <= 1'b0;
      end
   end

   // out_en only masks the visible data; state keeps advancing underneath.
   assign out_data  = out_en ? r_out : '0;
   assign out_valid = r_valid;
   assign filled    = r_filled;

endmodule

// File: tb/tb_moving_avg_multi.sv
// Directed, table-driven bench for moving_avg_multi at default parameters
// (3 channels, 2-bit samples, window 4, 4-bit result fields).
module tb_moving_avg_multi;

   localparam int CHANNELS = 3;
   localparam int DATA_W   = 2;
   localparam int LOG2_WIN = 2;
   localparam int IN_W     = CHANNELS * DATA_W;
   localparam int OUT_TW   = CHANNELS * (DATA_W + LOG2_WIN);

   logic              clk;
   logic              rst_n;
   logic              ena;
   logic              in_valid;
   logic [IN_W-1:0]   in_data;
   logic              clear;
   logic              mode;
   logic              out_en;
   logic              out_valid;
   logic [OUT_TW-1:0] out_data;
   logic              filled;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic              ena;
      logic              vld;
      logic              clr;
      logic              mode;
      logic              oen;
      logic [IN_W-1:0]   data;
      logic              e_ov;
      logic [OUT_TW-1:0] e_out;
      logic              e_f;
   } vec_t;

   vec_t vecs[$];

   moving_avg_multi #(
      .CHANNELS(CHANNELS),
      .DATA_W  (DATA_W),
      .LOG2_WIN(LOG2_WIN)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .in_valid (in_valid),
      .in_data  (in_data),
      .clear    (clear),
      .mode     (mode),
      .out_en   (out_en),
      .out_valid(out_valid),
      .out_data (out_data),
      .filled   (filled)
   );

   // Clock: 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic add(input logic e, input logic v, input logic c, input logic m,
                      input logic o, input logic [IN_W-1:0] d,
                      input logic eov, input logic [OUT_TW-1:0] eout, input logic ef);
      vec_t t;
      t.ena = e; t.vld = v; t.clr = c; t.mode = m; t.oen = o; t.data = d;
      t.e_ov = eov; t.e_out = eout; t.e_f = ef;
      vecs.push_back(t);
   endtask

   task automatic check_outs(input string tag, input logic eov,
                             input logic [OUT_TW-1:0] eout, input logic ef);
      checks++;
      if (out_valid !== eov) begin
         errors++;
         $display("FAIL %s out_valid got %b want %b", tag, out_valid, eov);
      end
      checks++;
      if (out_data !== eout) begin
         errors++;
         $display("FAIL %s out_data got %h want %h", tag, out_data, eout);
      end
      checks++;
      if (filled !== ef) begin
         errors++;
         $display("FAIL %s filled got %b want %b", tag, filled, ef);
      end
   endtask

   // Drive inputs, take one rising edge, sample 1 ns later.
   task automatic step(input logic e, input logic v, input logic c, input logic m,
                       input logic o, input logic [IN_W-1:0] d);
      ena = e; in_valid = v; clear = c; mode = m; out_en = o; in_data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; in_data = '0;
      clear = 1'b0; mode = 1'b0; out_en = 1'b1;

      // Fill and steady state, sum mode, ch0 = 3.
      add(1,1,0,1,1, 6'b000011, 1, 12'h003, 0);
      add(1,1,0,1,1, 6'b000011, 1, 12'h006, 0);
      add(1,1,0,1,1, 6'b000011, 1, 12'h009, 0);
      add(1,1,0,1,1, 6'b000011, 1, 12'h00C, 1);
      add(1,1,0,1,1, 6'b000000, 1, 12'h009, 1);
      add(1,0,1,1,1, 6'b000000, 0, 12'h000, 0);
      // Average mode, same stream.
      add(1,1,0,0,1, 6'b000011, 1, 12'h000, 0);
      add(1,1,0,0,1, 6'b000011, 1, 12'h001, 0);
      add(1,1,0,0,1, 6'b000011, 1, 12'h002, 0);
      add(1,1,0,0,1, 6'b000011, 1, 12'h003, 1);
      add(1,1,0,0,1, 6'b000000, 1, 12'h002, 1);
      add(1,0,1,0,1, 6'b000000, 0, 12'h000, 0);
      // Channel independence: ch0=1, ch1=2, ch2=3.
      add(1,1,0,1,1, 6'b111001, 1, 12'h321, 0);
      add(1,1,0,1,1, 6'b111001, 1, 12'h642, 0);
      add(1,1,0,1,1, 6'b111001, 1, 12'h963, 0);
      add(1,1,0,1,1, 6'b111001, 1, 12'hC84, 1);
      add(1,1,0,0,1, 6'b111001, 1, 12'h321, 1);
      // Gap of 5 idle cycles: hold value, no pulse.
      for (int i = 0; i < 5; i++) add(1,0,0,0,1, 6'b000000, 0, 12'h321, 1);
      // Mode flip without an accept does not change the held value.
      add(1,0,0,1,1, 6'b000000, 0, 12'h321, 1);
      // out_en low: data masked while sums advance to 3,6,9 then 2,4,6.
      add(1,1,0,1,0, 6'b000000, 1, 12'h000, 1);
      add(1,1,0,1,0, 6'b000000, 1, 12'h000, 1);
      add(1,0,0,1,1, 6'b000000, 0, 12'h642, 1);
      // ena low: sample and clear both ignored.
      add(0,1,1,1,1, 6'b111111, 0, 12'h642, 1);
      add(0,1,0,0,1, 6'b111111, 0, 12'h642, 1);
      // Clear collides with a sample: sample dropped.
      add(1,1,1,1,1, 6'b000011, 0, 12'h000, 0);
      add(1,1,0,1,1, 6'b000011, 1, 12'h003, 0);

      #22 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outs("reset_state", 1'b0, 12'h000, 1'b0);

      for (int k = 0; k < vecs.size(); k++) begin
         step(vecs[k].ena, vecs[k].vld, vecs[k].clr, vecs[k].mode,
              vecs[k].oen, vecs[k].data);
         check_outs($sformatf("vec%0d", k), vecs[k].e_ov, vecs[k].e_out, vecs[k].e_f);
      end

      // Async reset mid-stream, asserted between clock edges.
      ena = 1'b1; in_valid = 1'b1; clear = 1'b0; mode = 1'b1; out_en = 1'b1;
      in_data = 6'b000011;
      #2 rst_n = 1'b0;
      #1;
      check_outs("async_reset", 1'b0, 12'h000, 1'b0);
      in_valid = 1'b0;
      #4 rst_n = 1'b1;
      step(1,1,0,1,1, 6'b000010);
      check_outs("post_reset_1", 1'b1, 12'h002, 1'b0);
      step(1,1,0,1,1, 6'b000010);
      check_outs("post_reset_2", 1'b1, 12'h004, 1'b0);
      step(1,0,0,1,1, 6'b000000);
      check_outs("post_reset_idle", 1'b0, 12'h004, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
